ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: CLK cycles the PS/2 clock is held low before the request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum CLK cycles from clock release to completion (20 ms at 50 MHz).
REQ-003 SHALL have parameter FILTER_LEN, default 8: consecutive agreeing samples needed to change a filtered line level.
REQ-004 Port CLK, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 Port nRESET, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port DATA, input, 8 bits: byte to send to the keyboard; latched on an accepted START.
REQ-007 Port START, input, 1 bit: request to transmit; sampled high for one cycle.
REQ-008 Port BUSY, output, 1 bit: high from the cycle after an accepted START until the cycle DONE or ERROR is asserted.
REQ-009 Port DONE, output, 1 bit: one-cycle pulse; byte sent and acknowledged by the device.
REQ-010 Port ERROR, output, 1 bit: one-cycle pulse; missing acknowledge or timeout.
REQ-011 Port PS2_CLK_IN, input, 1 bit: PS/2 clock line level, asynchronous.
REQ-012 Port PS2_DATA_IN, input, 1 bit: PS/2 data line level, asynchronous.
REQ-013 Port PS2_CLK_OE, output, 1 bit: 1 = pull the PS/2 clock line low; 0 = release it (open-drain).
REQ-014 Port PS2_DATA_OE, output, 1 bit: 1 = pull the PS/2 data line low; 0 = release it (open-drain).

Function
REQ-015 Each PS2_*_IN SHALL pass a 2-FF synchronizer, then a filter whose output changes only after FILTER_LEN consecutive equal samples. Filter output after reset = 1.
REQ-016 A falling edge SHALL be the filtered clock going 1->0. It is detected in the cycle the filter output changes.
REQ-017 States SHALL be IDLE, INHIBIT, REQ, SEND, ACK, RELEASE.
REQ-018 IDLE: both OE are 0. If START=1, latch DATA, compute parity P = odd parity of DATA (~^DATA), set CLK_OE=1, clear the counter, go to INHIBIT.
REQ-019 START SHALL be ignored in every state other than IDLE.
REQ-020 INHIBIT: count cycles. After INHIBIT_CYCLES cycles, set DATA_OE=1 (start bit) and go to REQ.
REQ-021 REQ: lasts exactly one cycle with both lines pulled low. Then set CLK_OE=0, bit index=0, clear the timeout counter, go to SEND.
REQ-022 SEND: on each falling edge, drive bit[index] and increment index.
  - Indices 0-7: DATA[0..7], LSB first.
  - Index 8: P.
  - Index 9: stop bit.
  - Driving 1 = DATA_OE=0; driving 0 = DATA_OE=1.
  - After the edge that drives index 9, go to ACK.
REQ-023 ACK: on the next falling edge, sample filtered data.
  - 0: go to RELEASE.
  - 1: pulse ERROR, go to IDLE.
REQ-024 RELEASE: once filtered clock and filtered data are both 1, pulse DONE and go to IDLE.
REQ-025 The timeout counter SHALL run in SEND, ACK and RELEASE. When it reaches TIMEOUT_CYCLES: release both lines, pulse ERROR, go to IDLE. If the timeout and a normal completion fall in the same cycle, the timeout wins: ERROR only.
REQ-026 DONE and ERROR SHALL never be asserted in the same cycle. BUSY SHALL be 0 in the cycle either pulse is high.
REQ-027 DATA_OE SHALL be 0 in every state except REQ, SEND and ACK.
REQ-028 CLK_OE SHALL be 1 only in INHIBIT and REQ.

Reset
REQ-029 When nRESET=0, the following SHALL be cleared immediately, without waiting for a CLK edge:
  - state = IDLE;
  - PS2_CLK_OE = PS2_DATA_OE = 0;
  - BUSY = DONE = ERROR = 0;
  - counters, bit index and latched byte = 0;
  - synchronizer/filter outputs = 1.
REQ-030 After reset deassertion, the block SHALL accept START from the first rising edge.

Verification (bench parameters: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000, FILTER_LEN=4; device model clocks at a 40-CLK period)
REQ-031 START with DATA=0xED:
  - CLK_OE=1 for 10 cycles, then 1 REQ cycle with both OE=1.
  - Bits seen after successive falling edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device acks -> DONE exactly once; BUSY falls the same cycle.
REQ-032 START with DATA=0x00: parity bit = 1; with the ack -> DONE. With DATA=0x01: parity bit = 0.
REQ-033 Device leaves data high on the 11th falling edge -> ERROR pulse, both OE=0, state IDLE, no DONE.
REQ-034 Device never clocks after REQ -> ERROR exactly 2000 cycles after CLK_OE falls; both OE=0.
REQ-035 nRESET=0 at bit index 4 -> both OE and BUSY go to 0 before the next CLK edge. A later START sends a full frame correctly.
REQ-036 Each of these produces no state or output change:
  - START pulse while BUSY=1;
  - 3-cycle low glitch on PS2_CLK_IN during SEND.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Bundle between a PS/2 host transmitter and its environment.
//   DATA/START  : byte and one-cycle transmit request toward the transmitter
//   BUSY/DONE/ERROR : transfer status from the transmitter
//   PS2_*_IN    : raw open-drain line levels seen at the pins
//   PS2_*_OE    : 1 = pull the corresponding line low
// master = environment side (requester + pad model), slave = transmitter.
interface ps2_host_tx_if;
    logic [7:0] DATA;
    logic       START;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;
    logic       PS2_CLK_IN;
    logic       PS2_DATA_IN;
    logic       PS2_CLK_OE;
    logic       PS2_DATA_OE;

    modport master (
        output DATA, START, PS2_CLK_IN, PS2_DATA_IN,
        input  BUSY, DONE, ERROR, PS2_CLK_OE, PS2_DATA_OE
    );

    modport slave (
        input  DATA, START, PS2_CLK_IN, PS2_DATA_IN,
        output BUSY, DONE, ERROR, PS2_CLK_OE, PS2_DATA_OE
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter.
// Inhibits the bus, issues a request-to-send, shifts out 8 data bits LSB
// first plus odd parity and stop on device clock falling edges, then checks
// the device acknowledge. A timeout guards everything after clock release.
// Ports:
//   CLK    : system clock, rising edge
//   nRESET : asynchronous active-low reset
//   bus    : ps2_host_tx_if.slave (DATA, START, BUSY, DONE, ERROR,
//            PS2_CLK_IN, PS2_DATA_IN, PS2_CLK_OE, PS2_DATA_OE)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic          CLK,
    input  logic          nRESET,
    ps2_host_tx_if.slave  bus
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SEND, ACK, RELEASE
    } state_t;

    // Line index 0 = PS/2 clock, 1 = PS/2 data.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       filt_q;
    logic [FLT_W-1:0] fcnt_q [2];
    logic [1:0]       flip_c;
    logic             clk_fall_c;

    state_t           state_q;
    logic [7:0]       byte_q;
    logic             par_q;
    logic [3:0]       idx_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             clk_oe_q;
    logic             data_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [9:0]       frame_c;

    // A filter flips on the FILTER_LEN-th consecutive disagreeing sample.
    always_comb begin
        flip_c = 2'b00;
        for (int i = 0; i < 2; i++) begin
            flip_c[i] = (sync2_q[i] != filt_q[i]) &&
                        (fcnt_q[i] == FLT_W'(FILTER_LEN - 1));
        end
    end

    // Falling edge is reported in the same cycle the filtered clock drops.
    assign clk_fall_c = flip_c[0] & filt_q[0];

    assign frame_c = {1'b1, par_q, byte_q};

    // Two-stage synchronizers followed by the glitch filters.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            sync1_q <= {bus.PS2_DATA_IN, bus.PS2_CLK_IN};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (flip_c[i]) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FLT_W'(1);
                end
            end
        end
    end

    // Transfer sequencer with registered line enables and status.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            par_q     <= 1'b0;
            idx_q     <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (bus.START) begin
                        byte_q    <= bus.DATA;
                        par_q     <= ~^bus.DATA;
                        clk_oe_q  <= 1'b1;
                        inh_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                        data_oe_q <= 1'b1;
                        state_q   <= REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + INH_W'(1);
                    end
                end
                REQ: begin
                    clk_oe_q <= 1'b0;
                    idx_q    <= '0;
                    to_cnt_q <= '0;
                    state_q  <= SEND;
                end
                default: begin
                    // SEND / ACK / RELEASE: timeout has priority over progress.
                    if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                        if (state_q == SEND) begin
                            if (clk_fall_c) begin
                                data_oe_q <= ~frame_c[idx_q];
                                idx_q     <= idx_q + 4'd1;
                                if (idx_q == 4'd9) state_q <= ACK;
                            end
                        end else if (state_q == ACK) begin
                            if (clk_fall_c) begin
                                if (!filt_q[1]) begin
                                    state_q <= RELEASE;
                                end else begin
                                    data_oe_q <= 1'b0;
                                    err_q     <= 1'b1;
                                    busy_q    <= 1'b0;
                                    state_q   <= IDLE;
                                end
                            end
                        end else begin
                            if (filt_q == 2'b11) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.ERROR       = err_q;
    assign bus.PS2_CLK_OE  = clk_oe_q;
    assign bus.PS2_DATA_OE = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 10;
    localparam int unsigned TO   = 2000;
    localparam int unsigned FL   = 4;
    localparam int unsigned HALF = 20;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic glitch   = 1'b0;
    logic prev_busy = 1'b0;

    int tests     = 0;
    int fails     = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int excl_viol = 0;

    ps2_host_tx_if bus ();

    // Open-drain lines: low if either side pulls.
    assign bus.PS2_CLK_IN  = dev_clk & ~glitch & ~bus.PS2_CLK_OE;
    assign bus.PS2_DATA_IN = dev_data & ~bus.PS2_DATA_OE;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FL)
    ) dut (
        .CLK    (clk),
        .nRESET (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters; a pulse must be exclusive and end a BUSY period.
    always @(negedge clk) begin
        if (bus.DONE === 1'b1) done_cnt++;
        if (bus.ERROR === 1'b1) err_cnt++;
        if ((bus.DONE === 1'b1 || bus.ERROR === 1'b1) &&
            (bus.BUSY !== 1'b0 || prev_busy !== 1'b1 || (bus.DONE === 1'b1 && bus.ERROR === 1'b1)))
            excl_viol++;
        prev_busy = bus.BUSY;
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        bus.DATA  = d;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic wait_release(output logic ok);
        int n;
        n = 0;
        while (!(bus.PS2_CLK_OE === 1'b0 && bus.PS2_DATA_OE === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
    endtask

    // Device side of one frame: 10 data-phase clocks, then the ack clock.
    task automatic dev_frame(input logic ack, input logic disturb,
                             output logic [9:0] bits, output logic ok);
        bits = '0;
        wait_release(ok);
        if (ok) begin
            repeat (HALF) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                bits[i] = bus.PS2_DATA_IN;
                dev_clk = 1'b1;
                if (disturb && i == 3) begin
                    repeat (5) @(negedge clk);
                    bus.DATA  = 8'hFF;
                    bus.START = 1'b1;
                    @(negedge clk);
                    bus.START = 1'b0;
                    repeat (3) @(negedge clk);
                    glitch = 1'b1;
                    repeat (3) @(negedge clk);
                    glitch = 1'b0;
                    repeat (HALF - 12) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
            dev_data = ~ack;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk  = 1'b1;
            dev_data = 1'b1;
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (bus.BUSY === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic ack, input logic disturb,
                             output logic [9:0] bits, output logic ok,
                             output int dd, output int de, output int dv);
        int d0, e0, v0;
        d0 = done_cnt; e0 = err_cnt; v0 = excl_viol;
        start_tx(d);
        dev_frame(ack, disturb, bits, ok);
        settle();
        dd = done_cnt - d0; de = err_cnt - e0; dv = excl_viol - v0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.BUSY, bus.DONE, bus.ERROR, bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {bus.BUSY, bus.DONE, bus.ERROR, bus.PS2_CLK_OE, bus.PS2_DATA_OE});
        end
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 3'b0) begin
            fails++;
            $display("FAIL reset_held: got %b want 000", {bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE});
        end
        // START present on the very first edge after release must be taken.
        rst_n     = 1'b1;
        bus.DATA  = 8'h12;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        tests++;
        if ({bus.BUSY, bus.PS2_CLK_OE} !== 2'b11) begin
            fails++;
            $display("FAIL reset_first_edge_start: got %b want 11", {bus.BUSY, bus.PS2_CLK_OE});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.BUSY, bus.PS2_CLK_OE} !== 2'b00) begin
            fails++;
            $display("FAIL reset_abort_inhibit: got %b want 00", {bus.BUSY, bus.PS2_CLK_OE});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_frame_ed();
        int n, d0, e0, v0;
        logic [9:0] bits;
        logic ok;
        d0 = done_cnt; e0 = err_cnt; v0 = excl_viol;
        start_tx(8'hED);
        tests++;
        if (bus.BUSY !== 1'b1) begin
            fails++;
            $display("FAIL ed_busy: got %b want 1", bus.BUSY);
        end
        n = 0;
        while (bus.PS2_CLK_OE === 1'b1 && bus.PS2_DATA_OE === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n != 10) begin
            fails++;
            $display("FAIL ed_inhibit_len: got %0d want 10", n);
        end
        tests++;
        if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 2'b11) begin
            fails++;
            $display("FAIL ed_req_lines: got %b want 11", {bus.PS2_CLK_OE, bus.PS2_DATA_OE});
        end
        @(negedge clk);
        tests++;
        if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 2'b01) begin
            fails++;
            $display("FAIL ed_after_req: got %b want 01", {bus.PS2_CLK_OE, bus.PS2_DATA_OE});
        end
        dev_frame(1'b1, 1'b0, bits, ok);
        settle();
        tests++;
        if (ok !== 1'b1 || bits !== 10'h3ED) begin
            fails++;
            $display("FAIL ed_bits: got %h ok=%b want 3ed", bits, ok);
        end
        tests++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || excl_viol - v0 != 0) begin
            fails++;
            $display("FAIL ed_done: got done=%0d err=%0d viol=%0d want 1 0 0",
                     done_cnt - d0, err_cnt - e0, excl_viol - v0);
        end
    endtask

    task automatic test_parity();
        logic [9:0] bits;
        logic ok;
        int dd, de, dv;
        run_frame(8'h00, 1'b1, 1'b0, bits, ok, dd, de, dv);
        tests++;
        if (ok !== 1'b1 || bits !== 10'h300) begin
            fails++;
            $display("FAIL par_00_bits: got %h want 300", bits);
        end
        tests++;
        if (dd != 1 || de != 0 || dv != 0) begin
            fails++;
            $display("FAIL par_00_done: got done=%0d err=%0d viol=%0d want 1 0 0", dd, de, dv);
        end
        run_frame(8'h01, 1'b1, 1'b0, bits, ok, dd, de, dv);
        tests++;
        if (ok !== 1'b1 || bits !== 10'h201) begin
            fails++;
            $display("FAIL par_01_bits: got %h want 201", bits);
        end
        tests++;
        if (dd != 1 || de != 0) begin
            fails++;
            $display("FAIL par_01_done: got done=%0d err=%0d want 1 0", dd, de);
        end
    endtask

    task automatic test_no_ack();
        logic [9:0] bits;
        logic ok;
        int dd, de, dv;
        run_frame(8'hA5, 1'b0, 1'b0, bits, ok, dd, de, dv);
        tests++;
        if (dd != 0 || de != 1 || dv != 0) begin
            fails++;
            $display("FAIL no_ack_pulses: got done=%0d err=%0d viol=%0d want 0 1 0", dd, de, dv);
        end
        tests++;
        if ({bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 3'b000) begin
            fails++;
            $display("FAIL no_ack_lines: got %b want 000", {bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE});
        end
    endtask

    task automatic test_timeout();
        int cyc, d0, e0;
        logic ok;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h55);
        wait_release(ok);
        cyc = 0;
        while (bus.ERROR !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (ok !== 1'b1 || cyc != 2000) begin
            fails++;
            $display("FAIL timeout_cycles: got %0d ok=%b want 2000", cyc, ok);
        end
        tests++;
        if ({bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 3'b000) begin
            fails++;
            $display("FAIL timeout_lines: got %b want 000", {bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE});
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
            fails++;
            $display("FAIL timeout_pulses: got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        logic ok;
        int dd, de, dv;
        start_tx(8'h35);
        wait_release(ok);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        // Bit 3 of 0x35 is 0, so data is being pulled low here.
        tests++;
        if (ok !== 1'b1 || {bus.BUSY, bus.PS2_DATA_OE} !== 2'b11) begin
            fails++;
            $display("FAIL mid_pre_reset: got %b ok=%b want 11", {bus.BUSY, bus.PS2_DATA_OE}, ok);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset_async: got %b want 000", {bus.BUSY, bus.PS2_CLK_OE, bus.PS2_DATA_OE});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_frame(8'h35, 1'b1, 1'b0, bits, ok, dd, de, dv);
        tests++;
        if (ok !== 1'b1 || bits !== 10'h335) begin
            fails++;
            $display("FAIL mid_refram_bits: got %h want 335", bits);
        end
        tests++;
        if (dd != 1 || de != 0) begin
            fails++;
            $display("FAIL mid_refram_done: got done=%0d err=%0d want 1 0", dd, de);
        end
    endtask

    task automatic test_busy_ignore();
        logic [9:0] bits;
        logic ok;
        int dd, de, dv, n;
        run_frame(8'h5A, 1'b1, 1'b1, bits, ok, dd, de, dv);
        tests++;
        if (ok !== 1'b1 || bits !== 10'h35A) begin
            fails++;
            $display("FAIL ignore_bits: got %h want 35a", bits);
        end
        tests++;
        if (dd != 1 || de != 0 || dv != 0) begin
            fails++;
            $display("FAIL ignore_done: got done=%0d err=%0d viol=%0d want 1 0 0", dd, de, dv);
        end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.BUSY !== 1'b0 || bus.PS2_CLK_OE !== 1'b0) n++;
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL ignore_no_restart: got %0d active cycles want 0", n);
        end
    endtask

    initial begin
        bus.DATA  = 8'h00;
        bus.START = 1'b0;
        test_reset();
        test_frame_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_busy_ignore();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
